// File: rtl/pa_fpu.sv
// Shared FPU arithmetic package: state encoding for the sequential mantissa multiplier,
// also used by the arith FSM.
package pa_fpu;

    typedef enum logic [2:0] {
        MUL_IDLE          = 3'd0,
        MUL_START         = 3'd1,
        MUL_PRODUCT_ADD   = 3'd2,
        MUL_PRODUCT_SHIFT = 3'd3,
        MUL_RESULT_SET    = 3'd4,
        MUL_RESULT_VALID  = 3'd5
    } e_mul_state;

endpackage

// File: rtl/fpu_mul_seq.sv
// Sequential shift-add multiplier for the FPU mantissa path: magnitude multiply with
// optional early termination, sign fixed up at the end, start/valid/ack handshake.
import pa_fpu::*;

module fpu_mul_seq #(
    parameter int WIDTH      = 24,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 abort_i,
    input  logic                 ack_i,
    output logic                 busy_o,
    output logic                 valid_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CW = $clog2(WIDTH + 1);

    e_mul_state           r_state;
    e_mul_state           w_nextState;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_product;
    logic [WIDTH-1:0]     r_mplier;
    logic [CW-1:0]        r_cnt;
    logic                 r_neg;
    logic [WIDTH-1:0]     w_absA;
    logic [WIDTH-1:0]     w_absB;
    logic                 w_lastIter;

    // The most negative operand negates to 2^(WIDTH-1), which still fits unsigned.
    assign w_absA = (signed_i && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
    assign w_absB = (signed_i && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;

    assign w_lastIter = (r_cnt == CW'(WIDTH - 1)) ||
                        (EARLY_TERM && (r_mplier[WIDTH-1:1] == '0));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= MUL_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            MUL_IDLE:          if (start_i) w_nextState = MUL_START;
            MUL_START:         w_nextState = MUL_PRODUCT_ADD;
            MUL_PRODUCT_ADD:   w_nextState = MUL_PRODUCT_SHIFT;
            MUL_PRODUCT_SHIFT: w_nextState = w_lastIter ? MUL_RESULT_SET : MUL_PRODUCT_ADD;
            MUL_RESULT_SET:    w_nextState = MUL_RESULT_VALID;
            MUL_RESULT_VALID:  if (ack_i) w_nextState = MUL_IDLE;
            default:           w_nextState = MUL_IDLE;
        endcase
        if (abort_i) begin
            w_nextState = MUL_IDLE;
        end
    end

    always_comb begin
        busy_o  = (r_state != MUL_IDLE);
        valid_o = (r_state == MUL_RESULT_VALID);
    end

    assign product_o = r_product;

    // Datapath is frozen on abort so the last delivered product survives.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_product <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
        end else if (!abort_i) begin
            case (r_state)
                MUL_IDLE: begin
                    if (start_i) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_absA};
                        r_mplier <= w_absB;
                        r_neg    <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    end
                end
                MUL_START: begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end
                MUL_PRODUCT_ADD: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                end
                MUL_PRODUCT_SHIFT: begin
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                end
                MUL_RESULT_SET: begin
                    r_product <= r_neg ? (~r_acc + 1'b1) : r_acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_mul_seq.sv
// Self-checking bench for fpu_mul_seq: three configurations (W=24/ET=1, W=8/ET=1,
// W=16/ET=0) driven from shared buses, checked against an arithmetic reference model.
`timescale 1ns/1ps

module tb_fpu_mul_seq;

    logic        clk = 1'b0;
    logic        arst;
    logic        start;
    logic        sgn;
    logic        ack;
    logic        abort;
    logic [1:0]  sel;
    logic [23:0] aBus;
    logic [23:0] bBus;
    logic [2:0]  busyV;
    logic [2:0]  validV;
    logic [47:0] p24;
    logic [15:0] p8;
    logic [31:0] p16;
    logic [47:0] prodSel;

    int checks   = 0;
    int failures = 0;
    logic [47:0] lastExp [3];

    typedef struct {
        logic [1:0]  sel;
        logic        sgn;
        logic [23:0] a;
        logic [23:0] b;
        logic [47:0] expP;
        int          expCycle;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    fpu_mul_seq #(.WIDTH(24), .EARLY_TERM(1'b1)) u24 (
        .clk(clk), .arst(arst), .start_i(start && sel == 2'd0), .signed_i(sgn),
        .a_i(aBus), .b_i(bBus), .abort_i(abort && sel == 2'd0), .ack_i(ack && sel == 2'd0),
        .busy_o(busyV[0]), .valid_o(validV[0]), .product_o(p24));

    fpu_mul_seq #(.WIDTH(8), .EARLY_TERM(1'b1)) u8 (
        .clk(clk), .arst(arst), .start_i(start && sel == 2'd1), .signed_i(sgn),
        .a_i(aBus[7:0]), .b_i(bBus[7:0]), .abort_i(abort && sel == 2'd1), .ack_i(ack && sel == 2'd1),
        .busy_o(busyV[1]), .valid_o(validV[1]), .product_o(p8));

    fpu_mul_seq #(.WIDTH(16), .EARLY_TERM(1'b0)) u16 (
        .clk(clk), .arst(arst), .start_i(start && sel == 2'd2), .signed_i(sgn),
        .a_i(aBus[15:0]), .b_i(bBus[15:0]), .abort_i(abort && sel == 2'd2), .ack_i(ack && sel == 2'd2),
        .busy_o(busyV[2]), .valid_o(validV[2]), .product_o(p16));

    assign prodSel = (sel == 2'd0) ? p24 : (sel == 2'd1) ? {32'b0, p8} : {16'b0, p16};

    function automatic int wOf(input logic [1:0] s);
        return (s == 2'd0) ? 24 : (s == 2'd1) ? 8 : 16;
    endfunction

    function automatic bit etOf(input logic [1:0] s);
        return (s != 2'd2);
    endfunction

    // Reference: true integer product of the operands as interpreted in the chosen mode.
    function automatic logic [47:0] refProduct(input int w, input bit sg,
                                               input logic [23:0] a, input logic [23:0] b);
        longint sa = longint'(a);
        longint sb = longint'(b);
        longint p;
        if (sg && a[w-1]) sa = sa - (longint'(1) << w);
        if (sg && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        return 48'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    // Reference: cycle in which valid first rises, 2k+3 with k from the multiplier magnitude.
    function automatic int refCycles(input int w, input bit et, input bit sg, input logic [23:0] b);
        longint ab = longint'(b);
        int k;
        if (sg && b[w-1]) ab = (longint'(1) << w) - ab;
        if (et) k = (ab == 0) ? 1 : $clog2(ab + 1);
        else    k = w;
        return 2 * k + 3;
    endfunction

    task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] s, input bit sg, input logic [23:0] a,
                                 input logic [23:0] b, input logic [47:0] expP,
                                 input int expCyc, input string tag);
        int n;
        @(negedge clk);
        sel = s; sgn = sg; aBus = a; bBus = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!validV[s] && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!validV[s]) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout actual=no_valid required=valid_by_cycle_%0d", tag, expCyc);
            @(negedge clk); abort = 1'b1;
            @(posedge clk); #1; abort = 1'b0;
        end else begin
            checkOutput({tag, " latency"}, 48'(n + 1), 48'(expCyc));
            checkOutput({tag, " product"}, prodSel, expP);
            @(negedge clk); ack = 1'b1;
            @(posedge clk); #1; ack = 1'b0;
            checkOutput({tag, " idle after ack"}, {46'b0, busyV[s], validV[s]}, 48'b0);
        end
        lastExp[s] = expP;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{2'd0, 1'b0, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 51};
        vecs[1]  = '{2'd0, 1'b0, 24'hABCDEF, 24'h000000, 48'h0,            5};
        vecs[2]  = '{2'd0, 1'b0, 24'h123456, 24'h000001, 48'h000000123456, 5};
        vecs[3]  = '{2'd1, 1'b1, 24'h80,     24'h7F,     48'hC080,         17};
        vecs[4]  = '{2'd1, 1'b1, 24'h80,     24'h80,     48'h4000,         19};
        vecs[5]  = '{2'd1, 1'b0, 24'h80,     24'h80,     48'h4000,         19};
        vecs[6]  = '{2'd2, 1'b0, 24'h1234,   24'h0001,   48'h1234,         35};
        vecs[7]  = '{2'd1, 1'b1, 24'hFF,     24'h01,     48'hFFFF,         5};
        vecs[8]  = '{2'd1, 1'b1, 24'h03,     24'hFF,     48'hFFFD,         5};
        vecs[9]  = '{2'd1, 1'b1, 24'h00,     24'h85,     48'h0,            17};
        vecs[10] = '{2'd2, 1'b1, 24'hFFFF,   24'hFFFF,   48'h1,            35};
        vecs[11] = '{2'd0, 1'b1, 24'h800000, 24'h800000, 48'h400000000000, 51};

        arst = 1'b1; start = 1'b0; sgn = 1'b0; ack = 1'b0; abort = 1'b0;
        sel = 2'd0; aBus = '0; bBus = '0;
        for (int i = 0; i < 3; i++) lastExp[i] = '0;
        #12;
        checkOutput("reset busy/valid", {42'b0, busyV, validV}, 48'b0);
        checkOutput("reset p24", p24, 48'b0);
        checkOutput("reset p8/p16", {p16, p8}, 48'b0);
        @(negedge clk);
        arst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].sgn, vecs[i].a, vecs[i].b,
                          vecs[i].expP, vecs[i].expCycle, $sformatf("vec%0d", i));
        end

        // Result held without ack; start pulses must not disturb it.
        begin
            int n;
            @(negedge clk);
            sel = 2'd0; sgn = 1'b0; aBus = 24'd3; bBus = 24'd5; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n = 0;
            while (!validV[0] && n < 300) begin
                @(posedge clk); #1;
                n++;
            end
            checkOutput("hold latency", 48'(n + 1), 48'd9);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                start = (i % 3 == 0);
                aBus = 24'hFFFFFF; bBus = 24'hFFFFFF;
                @(posedge clk); #1;
                checkOutput($sformatf("hold valid c%0d", i), {47'b0, validV[0]}, 48'd1);
                checkOutput($sformatf("hold product c%0d", i), p24, 48'd15);
            end
            @(negedge clk);
            start = 1'b0; ack = 1'b1;
            @(posedge clk); #1;
            ack = 1'b0;
            checkOutput("hold ack idle", {46'b0, busyV[0], validV[0]}, 48'b0);
            lastExp[0] = 48'd15;
            applyStimulus(2'd0, 1'b0, 24'd7, 24'd9, 48'd63, 11, "after hold");
        end

        // Abort in product_shift during cycle 7.
        @(negedge clk);
        sel = 2'd1; sgn = 1'b0; aBus = 24'h55; bBus = 24'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("abort pre busy", {47'b0, busyV[1]}, 48'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abort idle", {46'b0, busyV[1], validV[1]}, 48'b0);
        checkOutput("abort product kept", {32'b0, p8}, lastExp[1]);

        // Asynchronous reset while in product_add.
        @(negedge clk);
        sel = 2'd0; sgn = 1'b0; aBus = 24'h00ABCD; bBus = 24'hFFFFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        #2 arst = 1'b1;
        #1;
        checkOutput("arst busy/valid", {42'b0, busyV, validV}, 48'b0);
        checkOutput("arst products", p24 | {32'b0, p8} | {16'b0, p16}, 48'b0);
        @(negedge clk);
        arst = 1'b0;
        for (int i = 0; i < 3; i++) lastExp[i] = '0;

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  s;
            bit          sg;
            int          w;
            logic [23:0] m;
            logic [23:0] a;
            logic [23:0] b;
            s  = 2'($urandom_range(0, 2));
            sg = 1'($urandom_range(0, 1));
            w  = wOf(s);
            m  = 24'((32'd1 << w) - 1);
            a  = 24'($urandom) & m;
            case ($urandom_range(0, 3))
                0: b = 24'($urandom) & m;
                1: b = 24'($urandom & ((32'd1 << $urandom_range(0, w)) - 1)) & m;
                2: b = 24'(32'd1 << (w - 1));
                default: b = m;
            endcase
            applyStimulus(s, sg, a, b, refProduct(w, sg, a, b),
                          refCycles(w, etOf(s), sg, b), $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
